zed_button_event: RTL and testbench
===================================

Name: zed_button_event

Overview:
- Per-button event generator. Sits directly downstream of the switch/button debouncer and consumes its debounced button outputs.
- Turns each debounced level into single-cycle press, release, long-press and auto-repeat pulses, plus a held flag.
- Feeds the board-level control logic (LED demos, menu stepping) in place of raw levels.

Parameters:
BUTTON_COUNT, 5, number of independent button channels
COUNTER_WIDTH, 24, width of per-channel hold counter and threshold inputs

Ports:
i_clock  input  1  system clock
i_reset  input  1  asynchronous active-high reset
i_buttons  input  BUTTON_COUNT  debounced button levels, 1 = pressed, synchronous to i_clock
i_long_press_count  input  COUNTER_WIDTH  hold cycles to long-press; 0 = long-press/repeat disabled
i_repeat_count  input  COUNTER_WIDTH  cycles between repeat pulses after long-press; 0 = repeat disabled
o_press  output  BUTTON_COUNT  1-cycle pulse on press
o_release  output  BUTTON_COUNT  1-cycle pulse on release
o_long_press  output  BUTTON_COUNT  1-cycle pulse when hold reaches threshold
o_repeat  output  BUTTON_COUNT  1-cycle periodic pulse while held beyond long-press
o_held  output  BUTTON_COUNT  level, 1 while channel not IDLE

Interface: one clock; reset is asynchronous and active-high. Ports are i_clock and i_reset.

Behaviour:
- Reset (async assert, sync deassert by system):
  - All outputs 0, all channels IDLE, counters 0, previous-sample register 0.
  - A button held through reset release is reported as a fresh press at the first edge.
- Channels are fully independent. Threshold inputs are shared and sampled live every cycle.
- All outputs are registered. Event sampled at edge E appears during the cycle after E.
- Per-channel FSM states: IDLE, PRESSED, LONG. Counter c.
- IDLE:
  - Edge with i_buttons=1 and previous sample 0 (call it E0): o_press pulse, go to PRESSED, c<=1.
- PRESSED, button sampled 1:
  - If L!=0 and c>=L: o_long_press pulse, go to LONG, c<=1.
  - Otherwise c<=c+1, saturating at all-ones.
  - Net effect: long-press fires at edge E0+L.
- LONG, button sampled 1:
  - If R!=0 and c>=R: o_repeat pulse, c<=1.
  - Otherwise c<=c+1, saturating.
  - Net effect: repeats at edges E0+L+R, E0+L+2R, ...
- PRESSED or LONG, button sampled 0: o_release pulse, go to IDLE, c<=0.
  - Release takes priority over a threshold hit on the same edge; no long/repeat pulse is emitted.
- o_held = (state != IDLE), registered with the state.
- Pulse exclusivity: per channel, at most one of press/release/long/repeat is high in any cycle.
- Threshold changes mid-hold: >= comparison is used, so lowering a threshold below c fires on the next edge. Raising it simply delays firing.
- L=0 keeps the channel in PRESSED until release (no long, no repeat).
- R=0 in LONG produces no repeats.
- 1-cycle press (1 then 0): o_press in the cycle after E0, o_release in the cycle after E0+1.
- Saturation: c never wraps. At c = all-ones with threshold = all-ones, fire occurs normally.

Decomposition:
- Package zed_button_event_pkg holds:
  - typedef enum logic [1:0] {IDLE, PRESSED, LONG} button_state_t
  - default COUNTER_WIDTH constant
- Sub-module zed_button_event_channel: one button's previous-sample register, FSM, counter and the four pulses plus held.
- Top-level instantiates BUTTON_COUNT channels in a generate loop, sharing i_long_press_count and i_repeat_count.

Test Plan:
- Reset with i_buttons=0 → all outputs 0. Raise bit0 at E0 → o_press[0]=1 for exactly one cycle, o_held[0]=1, other channels silent.
- L=4, R=3, hold bit0 for 12 edges → o_long_press[0] after E4, o_repeat[0] after E7 and E10, o_release[0] one cycle after the drop.
- L=4, release sampled at E4 → o_release[0] only; o_long_press[0] never asserts; o_held[0]=0 next cycle.
- L=0, hold 100 cycles → no long/repeat pulses; o_held stays 1; release pulse on drop. Separately, L=4, R=0 → single long pulse, no repeats.
- Bit0 and bit3 pressed on the same edge, bit3 released 2 cycles later → independent correct pulses per channel. Assert i_reset mid-LONG → outputs 0 immediately (async); button still high after release → o_press again.
- Hold to c=10, lower L from 20 to 5 → o_long_press on the next edge.

Source files
------------

// File: rtl/zed_button_event_pkg.sv
// zed_button_event_pkg: shared channel state type and default sizing
package zed_button_event_pkg;
  localparam int DEFAULT_BUTTON_COUNT = 5;
  localparam int DEFAULT_COUNTER_WIDTH = 24;
  typedef enum logic [1:0] {IDLE, PRESSED, LONG} button_state_t;
endpackage

// File: rtl/zed_button_event_channel.sv
// zed_button_event_channel: one button's edge detect, hold FSM, hold counter and event pulses
module zed_button_event_channel
  import zed_button_event_pkg::*;
#(
  parameter int COUNTER_WIDTH = DEFAULT_COUNTER_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     button,
  input  logic [COUNTER_WIDTH-1:0] long_press_count,
  input  logic [COUNTER_WIDTH-1:0] repeat_count,
  output logic                     press_pulse,
  output logic                     release_pulse,
  output logic                     long_pulse,
  output logic                     repeat_pulse,
  output logic                     held
);
  localparam logic [COUNTER_WIDTH-1:0] ONE = COUNTER_WIDTH'(1);
  button_state_t state, state_d;
  logic [COUNTER_WIDTH-1:0] count, count_d, count_sat;
  logic prev, press_d, release_d, long_d, repeat_d;
  // Next state, counter and pulses; release on a 0 sample beats any threshold hit
  always_comb begin
    state_d = state;
    count_d = count;
    press_d = 1'b0;
    release_d = 1'b0;
    long_d = 1'b0;
    repeat_d = 1'b0;
    count_sat = &count ? count : count + ONE;
    if (state == IDLE) begin
      if (button && !prev) begin
        press_d = 1'b1;
        state_d = PRESSED;
        count_d = ONE;
      end
    end else if (!button) begin
      release_d = 1'b1;
      state_d = IDLE;
      count_d = '0;
    end else if (state == PRESSED && long_press_count != '0 && count >= long_press_count) begin
      long_d = 1'b1;
      state_d = LONG;
      count_d = ONE;
    end else if (state == LONG && repeat_count != '0 && count >= repeat_count) begin
      repeat_d = 1'b1;
      count_d = ONE;
    end else begin
      count_d = count_sat;
    end
  end
  // State, counter, previous sample and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
      prev <= 1'b0;
      press_pulse <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse <= 1'b0;
      repeat_pulse <= 1'b0;
      held <= 1'b0;
    end else begin
      state <= state_d;
      count <= count_d;
      prev <= button;
      press_pulse <= press_d;
      release_pulse <= release_d;
      long_pulse <= long_d;
      repeat_pulse <= repeat_d;
      held <= state_d != IDLE;
    end
  end
endmodule

// File: rtl/zed_button_event.sv
// zed_button_event: per-button press/release/long-press/repeat pulse generator with held flags
module zed_button_event
  import zed_button_event_pkg::*;
#(
  parameter int BUTTON_COUNT = DEFAULT_BUTTON_COUNT,
  parameter int COUNTER_WIDTH = DEFAULT_COUNTER_WIDTH
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic [BUTTON_COUNT-1:0]  i_buttons,
  input  logic [COUNTER_WIDTH-1:0] i_long_press_count,
  input  logic [COUNTER_WIDTH-1:0] i_repeat_count,
  output logic [BUTTON_COUNT-1:0]  o_press,
  output logic [BUTTON_COUNT-1:0]  o_release,
  output logic [BUTTON_COUNT-1:0]  o_long_press,
  output logic [BUTTON_COUNT-1:0]  o_repeat,
  output logic [BUTTON_COUNT-1:0]  o_held
);
  for (genvar i = 0; i < BUTTON_COUNT; i++) begin : g_channel
    zed_button_event_channel #(.COUNTER_WIDTH(COUNTER_WIDTH)) u_channel (
      .clk             (i_clock),
      .rst             (i_reset),
      .button          (i_buttons[i]),
      .long_press_count(i_long_press_count),
      .repeat_count    (i_repeat_count),
      .press_pulse     (o_press[i]),
      .release_pulse   (o_release[i]),
      .long_pulse      (o_long_press[i]),
      .repeat_pulse    (o_repeat[i]),
      .held            (o_held[i])
    );
  end
endmodule

// File: tb/tb_zed_button_event.sv
// tb_zed_button_event: randomized and directed checks against a timestamp-based event model
module tb_zed_button_event;
  localparam int N = 5;
  localparam int W = 24;
  logic clk = 1'b0;
  logic rst;
  logic [N-1:0] btn;
  logic [W-1:0] lp, rp;
  logic [N-1:0] o_press, o_release, o_long_press, o_repeat, o_held;
  logic [N-1:0] e_press, e_release, e_long, e_repeat, e_held;
  logic [5*N-1:0] obs, exp_v;
  int errors = 0;
  int checks = 0;
  int edge_n = 0;
  bit m_prev[N], m_on[N], m_long[N];
  int m_last[N];

  zed_button_event #(.BUTTON_COUNT(N), .COUNTER_WIDTH(W)) dut (
    .i_clock(clk), .i_reset(rst), .i_buttons(btn),
    .i_long_press_count(lp), .i_repeat_count(rp),
    .o_press(o_press), .o_release(o_release), .o_long_press(o_long_press),
    .o_repeat(o_repeat), .o_held(o_held)
  );

  always #5 clk = ~clk;
  assign obs = {o_press, o_release, o_long_press, o_repeat, o_held};
  assign exp_v = {e_press, e_release, e_long, e_repeat, e_held};

  // Model: a held button fires when the time since its last event (press or fire) reaches the active threshold
  function automatic void model_reset();
    for (int c = 0; c < N; c++) begin
      m_prev[c] = 0; m_on[c] = 0; m_long[c] = 0; m_last[c] = 0;
    end
    e_press = '0; e_release = '0; e_long = '0; e_repeat = '0; e_held = '0;
  endfunction

  function automatic void model_edge();
    int thr;
    edge_n++;
    e_press = '0; e_release = '0; e_long = '0; e_repeat = '0;
    for (int c = 0; c < N; c++) begin
      if (!m_on[c]) begin
        if (btn[c] && !m_prev[c]) begin
          e_press[c] = 1; m_on[c] = 1; m_long[c] = 0; m_last[c] = edge_n;
        end
      end else if (!btn[c]) begin
        e_release[c] = 1; m_on[c] = 0;
      end else begin
        thr = m_long[c] ? int'(rp) : int'(lp);
        if (thr != 0 && edge_n - m_last[c] >= thr) begin
          if (m_long[c]) e_repeat[c] = 1; else e_long[c] = 1;
          m_long[c] = 1; m_last[c] = edge_n;
        end
      end
      e_held[c] = m_on[c];
      m_prev[c] = btn[c];
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    rst = 1; btn = '0; lp = 4; rp = 3;
    model_reset();
    tick(); tick();
    checks++;
    if (obs !== '0) begin errors++; $display("FAIL reset_outputs got=%h want=0", obs); end
    #4 rst = 0;
  endtask

  task automatic test_press();
    btn = 5'b00001;
    tick();
    checks++;
    if (o_press !== 5'b00001 || o_held !== 5'b00001 || obs !== exp_v) begin
      errors++; $display("FAIL press_first got=%h want=%h", obs, exp_v);
    end
    tick();
    checks++;
    if (o_press !== 5'b0 || obs !== exp_v) begin errors++; $display("FAIL press_single got=%h want=%h", obs, exp_v); end
    btn = '0;
    tick();
    checks++;
    if (o_release !== 5'b00001 || obs !== exp_v) begin errors++; $display("FAIL press_release got=%h want=%h", obs, exp_v); end
    tick();
  endtask

  task automatic test_long_repeat();
    int long_seen = 0, rep_seen = 0;
    lp = 4; rp = 3; btn = 5'b00001;
    for (int i = 0; i < 12; i++) begin
      tick();
      long_seen += int'(o_long_press[0]); rep_seen += int'(o_repeat[0]);
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL long_repeat cyc=%0d got=%h want=%h", i, obs, exp_v); end
    end
    checks++;
    if (long_seen != 1 || rep_seen != 2) begin
      errors++; $display("FAIL long_repeat_counts got=%0d/%0d want=1/2", long_seen, rep_seen);
    end
    btn = '0;
    tick();
    checks++;
    if (o_release[0] !== 1'b1 || obs !== exp_v) begin errors++; $display("FAIL long_repeat_release got=%h want=%h", obs, exp_v); end
    tick();
  endtask

  task automatic test_release_priority();
    lp = 4; btn = 5'b00001;
    for (int i = 0; i < 4; i++) tick();
    btn = '0;
    tick();
    checks++;
    if (o_release[0] !== 1'b1 || o_long_press[0] !== 1'b0 || obs !== exp_v) begin
      errors++; $display("FAIL release_priority got=%h want=%h", obs, exp_v);
    end
    tick();
    checks++;
    if (o_held[0] !== 1'b0 || o_long_press[0] !== 1'b0) begin
      errors++; $display("FAIL release_priority_after got=%h want=0", obs);
    end
  endtask

  task automatic test_disabled();
    int long_seen = 0, rep_seen = 0;
    lp = 0; rp = 3; btn = 5'b00001;
    for (int i = 0; i < 100; i++) begin
      tick();
      long_seen += int'(o_long_press[0]) + int'(o_repeat[0]);
      checks++;
      if (obs !== exp_v || o_held[0] !== 1'b1) begin errors++; $display("FAIL long_disabled cyc=%0d got=%h want=%h", i, obs, exp_v); end
    end
    checks++;
    if (long_seen != 0) begin errors++; $display("FAIL long_disabled_count got=%0d want=0", long_seen); end
    btn = '0; tick(); tick();
    lp = 4; rp = 0; btn = 5'b00001; long_seen = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      long_seen += int'(o_long_press[0]); rep_seen += int'(o_repeat[0]);
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL repeat_disabled cyc=%0d got=%h want=%h", i, obs, exp_v); end
    end
    checks++;
    if (long_seen != 1 || rep_seen != 0) begin
      errors++; $display("FAIL repeat_disabled_counts got=%0d/%0d want=1/0", long_seen, rep_seen);
    end
    btn = '0; tick(); tick();
  endtask

  task automatic test_multi();
    lp = 4; rp = 3; btn = 5'b01001;
    tick();
    checks++;
    if (o_press !== 5'b01001 || obs !== exp_v) begin errors++; $display("FAIL multi_press got=%h want=%h", obs, exp_v); end
    tick();
    btn = 5'b00001;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL multi cyc=%0d got=%h want=%h", i, obs, exp_v); end
    end
    btn = '0; tick(); tick();
  endtask

  task automatic test_reset_mid_long();
    lp = 4; rp = 3; btn = 5'b00010;
    for (int i = 0; i < 6; i++) tick();
    checks++;
    if (o_held[1] !== 1'b1) begin errors++; $display("FAIL mid_long_held got=%b want=1", o_held[1]); end
    rst = 1;
    #1;
    checks++;
    if (obs !== '0) begin errors++; $display("FAIL async_reset got=%h want=0", obs); end
    model_reset();
    #3 rst = 0;
    tick();
    checks++;
    if (o_press !== 5'b00010 || obs !== exp_v) begin errors++; $display("FAIL press_after_reset got=%h want=%h", obs, exp_v); end
    btn = '0; tick(); tick();
  endtask

  task automatic test_threshold_change();
    lp = 20; rp = 0; btn = 5'b00100;
    for (int i = 0; i < 10; i++) tick();
    lp = 5;
    tick();
    checks++;
    if (o_long_press !== 5'b00100 || obs !== exp_v) begin errors++; $display("FAIL threshold_lower got=%h want=%h", obs, exp_v); end
    btn = '0; tick(); tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      for (int c = 0; c < N; c++) if ($urandom_range(0, 7) == 0) btn[c] = ~btn[c];
      if ($urandom_range(0, 31) == 0) lp = W'($urandom_range(0, 6));
      if ($urandom_range(0, 31) == 0) rp = W'($urandom_range(0, 4));
      tick();
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL random cyc=%0d got=%h want=%h", i, obs, exp_v); end
    end
  endtask

  initial begin
    test_reset();
    test_press();
    test_long_repeat();
    test_release_priority();
    test_disabled();
    test_multi();
    test_reset_mid_long();
    test_threshold_change();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
